// File: rtl/extbus_seq.sv
// External bus sequencer: runs one T1..T4 read/write cycle per core request.
// WAIT stretches T3; a stuck WAIT times out after WAIT_LIMIT extra cycles.
module extbus_seq #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic        CLK,
  input  logic        SYNC_RES,
  input  logic        req,
  input  logic        wr,
  input  logic [7:0]  adl,
  input  logic [7:0]  adh,
  input  logic [7:0]  dout,
  input  logic [7:0]  D_in,
  input  logic        WAIT,
  output logic [15:0] A,
  output logic [7:0]  D_out,
  output logic        D_oe,
  output logic        n_rd,
  output logic        n_wr,
  output logic [7:0]  DL,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int CW =
    (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(WAIT_LIMIT);

  typedef enum logic [2:0] {
    IDLE, T1, T2, T3, T4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          wr_q;
  logic          start;

  assign start = req && (state == IDLE || state == T4);

  always_ff @(posedge CLK) begin
    if (SYNC_RES) begin
      state <= IDLE;
      cnt   <= '0;
      wr_q  <= 1'b0;
      A     <= 16'h0000;
      D_out <= 8'h00;
      D_oe  <= 1'b0;
      n_rd  <= 1'b1;
      n_wr  <= 1'b1;
      DL    <= 8'h00;
      ack   <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE, T4: begin
          if (start) begin
            state <= T1;
            cnt   <= '0;
            wr_q  <= wr;
            A     <= {adh, adl};
            D_out <= dout;
            D_oe  <= wr;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            D_oe  <= 1'b0;
            busy  <= 1'b0;
          end
        end
        T1: begin
          state <= T2;
          n_rd  <= wr_q;
          n_wr  <= ~wr_q;
        end
        T2: state <= T3;
        T3: begin
          // leave on WAIT low, or on timeout once the budget is spent
          if (!WAIT || cnt == LIM) begin
            state <= T4;
            n_rd  <= 1'b1;
            n_wr  <= 1'b1;
            ack   <= 1'b1;
            err   <= WAIT;
            if (!wr_q)
              DL <= WAIT ? 8'hFF : D_in;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_extbus_seq.sv
// Self-checking bench for extbus_seq: directed cases plus random
// transactions checked cycle by cycle against a timing model.
module tb_extbus_seq;

  localparam int LIM = 15;

  logic        CLK = 1'b0;
  logic        SYNC_RES;
  logic        req;
  logic        wr;
  logic [7:0]  adl;
  logic [7:0]  adh;
  logic [7:0]  dout;
  logic [7:0]  D_in;
  logic        WAIT;
  logic [15:0] A;
  logic [7:0]  D_out;
  logic        D_oe;
  logic        n_rd;
  logic        n_wr;
  logic [7:0]  DL;
  logic        ack;
  logic        err;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [7:0]  exp_dl;
  logic [15:0] exp_a;

  extbus_seq #(.WAIT_LIMIT(LIM)) dut (
    .CLK(CLK), .SYNC_RES(SYNC_RES), .req(req), .wr(wr),
    .adl(adl), .adh(adh), .dout(dout), .D_in(D_in),
    .WAIT(WAIT), .A(A), .D_out(D_out), .D_oe(D_oe),
    .n_rd(n_rd), .n_wr(n_wr), .DL(DL), .ack(ack),
    .err(err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, 16'(busy), 16'h0);
    chk({tag, ".ack"},  16'(ack),  16'h0);
    chk({tag, ".err"},  16'(err),  16'h0);
    chk({tag, ".D_oe"}, 16'(D_oe), 16'h0);
    chk({tag, ".n_rd"}, 16'(n_rd), 16'h1);
    chk({tag, ".n_wr"}, 16'(n_wr), 16'h1);
    chk({tag, ".A"},    A,         exp_a);
    chk({tag, ".DL"},   16'(DL),   16'(exp_dl));
  endtask

  // One access with w wait cycles requested on WAIT; ack lands in
  // cycle 4+min(w,LIM), and w>LIM means a timeout.
  task automatic txn(input logic twr, input logic [15:0] taddr,
                     input logic [7:0] tdout, input logic [7:0] tdin,
                     input int w, input bit cin, input bit cout,
                     input logic nwr, input logic [15:0] naddr,
                     input logic [7:0] ndout);
    int  len;
    bit  tmo;
    bit  strobe;
    len = 4 + ((w > LIM) ? LIM : w);
    tmo = (w > LIM);
    if (!cin) begin
      req = 1'b1;
      wr = twr;
      {adh, adl} = taddr;
      dout = tdout;
      next_cycle();
    end
    for (int c = 1; c <= len; c++) begin
      WAIT = (c >= 3 && c < 3 + w);
      D_in = (c == len - 1) ? tdin : 8'($urandom);
      if (c == len) begin
        req = cout;
        wr = nwr;
        {adh, adl} = naddr;
        dout = ndout;
        if (!twr) exp_dl = tmo ? 8'hFF : tdin;
      end else begin
        req = 1'($urandom);
        wr = 1'($urandom);
        {adh, adl} = 16'($urandom);
        dout = 8'($urandom);
      end
      @(negedge CLK);
      strobe = (c >= 2 && c <= len - 1);
      chk("busy", 16'(busy), 16'h1);
      chk("A", A, taddr);
      chk("n_rd", 16'(n_rd), 16'(!(strobe && !twr)));
      chk("n_wr", 16'(n_wr), 16'(!(strobe && twr)));
      chk("D_oe", 16'(D_oe), 16'(twr));
      if (twr) chk("D_out", 16'(D_out), 16'(tdout));
      chk("ack", 16'(ack), 16'(c == len));
      chk("err", 16'(err), 16'(c == len && tmo));
      chk("DL", 16'(DL), 16'(exp_dl));
      next_cycle();
    end
    exp_a = taddr;
    if (!cout) begin
      req = 1'b0;
      WAIT = 1'b0;
      @(negedge CLK);
      chk_idle("after");
      next_cycle();
    end
  endtask

  initial begin
    logic        cwr, nwr_v;
    logic [15:0] cad, nad;
    logic [7:0]  cdo, cdi, ndo, ndi;
    int          cw, nw;
    bit          ch, co;

    SYNC_RES = 1'b1;
    req = 1'b1;
    wr = 1'b1;
    {adh, adl} = 16'hABCD;
    dout = 8'h77;
    D_in = 8'h00;
    WAIT = 1'b0;
    exp_dl = 8'h00;
    exp_a = 16'h0000;
    next_cycle();
    next_cycle();
    @(negedge CLK);
    chk_idle("reset");
    chk("reset.D_out", 16'(D_out), 16'h0);
    next_cycle();
    SYNC_RES = 1'b0;
    req = 1'b0;
    next_cycle();

    txn(1'b0, 16'hC012, 8'h00, 8'h5A, 0, 1'b0, 1'b0,
        1'b0, 16'h0, 8'h0);
    txn(1'b1, 16'hFF80, 8'h3C, 8'h99, 2, 1'b0, 1'b0,
        1'b0, 16'h0, 8'h0);
    txn(1'b0, 16'h4321, 8'h00, 8'h01, 40, 1'b0, 1'b0,
        1'b0, 16'h0, 8'h0);
    txn(1'b0, 16'h2222, 8'h00, 8'hA5, LIM, 1'b0, 1'b0,
        1'b0, 16'h0, 8'h0);
    txn(1'b0, 16'h0100, 8'h00, 8'h11, 0, 1'b0, 1'b1,
        1'b0, 16'h0101, 8'h00);
    txn(1'b0, 16'h0101, 8'h00, 8'h22, 0, 1'b1, 1'b0,
        1'b0, 16'h0, 8'h0);

    // reset during T2 of a read
    req = 1'b1;
    wr = 1'b0;
    {adh, adl} = 16'h1234;
    next_cycle();
    req = 1'b0;
    @(negedge CLK);
    chk("rst_mid.busy", 16'(busy), 16'h1);
    next_cycle();
    SYNC_RES = 1'b1;
    @(negedge CLK);
    chk("rst_mid.n_rd", 16'(n_rd), 16'h0);
    next_cycle();
    SYNC_RES = 1'b0;
    exp_dl = 8'h00;
    exp_a = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      WAIT = 1'($urandom);
      @(negedge CLK);
      chk_idle("rst_mid");
      next_cycle();
    end
    txn(1'b0, 16'h1234, 8'h00, 8'h6C, 1, 1'b0, 1'b0,
        1'b0, 16'h0, 8'h0);

    cwr = 1'($urandom);
    cad = 16'($urandom);
    cdo = 8'($urandom);
    cdi = 8'($urandom);
    cw = ($urandom_range(0, 7) == 0) ? LIM + 1 : $urandom_range(0, 4);
    ch = 1'b0;
    for (int i = 0; i < 30; i++) begin
      co = (i < 29) && ($urandom_range(0, 2) == 0);
      nwr_v = 1'($urandom);
      nad = 16'($urandom);
      ndo = 8'($urandom);
      ndi = 8'($urandom);
      nw = ($urandom_range(0, 7) == 0) ? LIM + 1 + $urandom_range(0, 2)
                                       : $urandom_range(0, 4);
      txn(cwr, cad, cdo, cdi, cw, ch, co, nwr_v, nad, ndo);
      cwr = nwr_v;
      cad = nad;
      cdo = ndo;
      cdi = ndi;
      cw = nw;
      ch = co;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/extbus_seq.md
EXTBUS_SEQ -- requirements
Module: extbus_seq

Interface
REQ-001 The block SHALL expose parameter WAIT_LIMIT, default 15, giving the maximum number of wait cycles inserted before a cycle is aborted.
REQ-002 CLK  in  1  single clock; every register SHALL update on the rising edge.
REQ-003 SYNC_RES  in  1  reset, synchronous, active-high.
REQ-004 req  in  1  core request; sampled in IDLE and T4 only.
REQ-005 wr  in  1  1=write, 0=read; captured with req.
REQ-006 adl  in  8  address low byte; captured with req.
REQ-007 adh  in  8  address high byte; captured with req.
REQ-008 dout  in  8  core write data; captured with req.
REQ-009 D_in  in  8  external data bus input.
REQ-010 WAIT  in  1  external wait request, active-high.
REQ-011 A  out  16  external address, {adh,adl} as captured.
REQ-012 D_out  out  8  external write data.
REQ-013 D_oe  out  1  D_out drive enable.
REQ-014 n_rd  out  1  read strobe, active-low.
REQ-015 n_wr  out  1  write strobe, active-low.
REQ-016 DL  out  8  read data returned to the core; holds the last completed read.
REQ-017 ack  out  1  one-cycle completion pulse.
REQ-018 err  out  1  one-cycle timeout pulse, coincident with ack.
REQ-019 busy  out  1  high in T1..T4.

Function
REQ-020 The FSM SHALL have the states IDLE, T1, T2, T3 and T4, all registered.
REQ-021 IDLE: if req=1, capture adl/adh/wr/dout and go to T1; otherwise stay in IDLE.
REQ-022 T1 SHALL go to T2 unconditionally, and T2 SHALL go to T3 unconditionally.
REQ-023 T3: WAIT=0 -> T4; WAIT=1 with wait count < WAIT_LIMIT -> stay in T3 and increment count; WAIT=1 with count == WAIT_LIMIT -> T4 flagged timeout.
REQ-024 The wait counter SHALL clear on every entry to T1 and SHALL be wide enough to hold WAIT_LIMIT without wrap.
REQ-025 T4 with req=1 SHALL capture a new request and go to T1; T4 with req=0 SHALL go to IDLE.
REQ-026 req in T1..T3 SHALL be ignored; there is no queueing.
REQ-027 A SHALL present the captured address from T1 through T4 and SHALL retain it in IDLE.
REQ-028 Read strobe: n_rd=0 in T2 and T3; otherwise 1.
REQ-029 Write strobe: n_wr=0 in T2 and T3; otherwise 1.
REQ-030 n_rd and n_wr SHALL never be low simultaneously.
REQ-031 For a write, D_oe=1 in T1..T4 with D_out equal to the captured dout; D_oe=0 otherwise.
REQ-032 For a read leaving T3 with WAIT=0, DL SHALL load D_in on that edge and be valid in T4.
REQ-033 For a read that times out, DL SHALL load 8'hFF.
REQ-034 A write SHALL leave DL unchanged.
REQ-035 ack SHALL equal 1 exactly in T4; err SHALL equal 1 in T4 only for a timed-out cycle.
REQ-036 Latency: req sampled at edge 0 gives T1 in cycle 1 and ack in cycle 4+n, where n is the number of wait cycles.
REQ-037 Back-to-back accesses with req held high SHALL complete one access per 4 cycles, with no IDLE cycle between them.
REQ-038 busy SHALL equal 1 in T1..T4 and 0 in IDLE.

Reset
REQ-039 SYNC_RES=1 at any edge, including mid-cycle, SHALL force state=IDLE and wait count=0.
REQ-040 SYNC_RES=1 SHALL also force A=16'h0000, D_out=8'h00, D_oe=0, n_rd=1, n_wr=1, DL=8'h00, ack=0, err=0 and busy=0.
REQ-041 SYNC_RES SHALL take priority over req.
REQ-042 An interrupted access SHALL produce no ack.

Verification
REQ-043 Reset: hold SYNC_RES 2 cycles -> all outputs at their REQ-039/REQ-040 values, n_rd=n_wr=1.
REQ-044 Read, no wait: req, wr=0, adh=C0, adl=12, D_in=5A, WAIT=0 -> A=C012 in cycles 1-4, n_rd=0 in cycles 2-3, ack=1 in cycle 4, DL=5A, err=0.
REQ-045 Write with 2 waits: wr=1, A=FF80, dout=3C, WAIT=1 for 2 T3 cycles -> D_oe=1 in cycles 1-6, n_wr=0 in cycles 2-5, ack in cycle 6, DL unchanged.
REQ-046 Timeout: WAIT stuck at 1, WAIT_LIMIT=15, read -> T3 in cycles 3-18, ack=err=1 in cycle 19, DL=FF, then IDLE.
REQ-047 Back-to-back: req held high for reads at 0100 then 0101 (D_in=11, then 22) -> acks in cycles 4 and 8, DL=11 then 22, busy continuously 1.
REQ-048 Reset mid-T2 of a read: SYNC_RES pulsed in cycle 2 -> next cycle IDLE, n_rd=1, no ack, DL=00; a following req completes normally.
